// File: rtl/pwm_seno_multi_if.sv
// pwm_seno_multi_if: control and status bundle for pwm_seno_multi.
// The generator sits on the slave side and the controller on the master side.
// pwm_n exists only when PWM_COMPL_EN is defined.
interface pwm_seno_multi_if #(
  parameter int R  = 6,
  parameter int CH = 3
);
  logic          en;
  logic          mode;
  logic [R-1:0]  duty_in;
  logic [CH-1:0] pwm_out;
  logic [5:0]    step_idx;
  logic          period_tick;
`ifdef PWM_COMPL_EN
  logic [CH-1:0] pwm_n;

  modport master (output en, mode, duty_in,
                  input  pwm_out, step_idx, period_tick, pwm_n);
  modport slave  (input  en, mode, duty_in,
                  output pwm_out, step_idx, period_tick, pwm_n);
`else
  modport master (output en, mode, duty_in,
                  input  pwm_out, step_idx, period_tick);
  modport slave  (input  en, mode, duty_in,
                  output pwm_out, step_idx, period_tick);
`endif
endinterface

// File: rtl/pwm_seno_multi.sv
// pwm_seno_multi: multi-channel sine-modulated PWM generator.
// A shared R-bit carrier counter drives one comparator per channel. Each
// channel reads a 36-step sine duty table, offset from its neighbour by
// PH_STEP steps. The table index advances once every N carrier periods.
// Duties are shadowed at carrier wrap, so a period never changes mid-flight.
// Bypass mode (mode=1) feeds duty_in to every channel instead of the table.
//
// Optional macro PWM_COMPL_EN adds complementary outputs pwm_n with DT cycles
// of both-low after every edge. Each channel then runs a small dead-time FSM:
//   state    | meaning
//   S_IDLE_N | low side active, pwm_n high
//   S_DT_UP  | both low, counting DT before raising pwm_out
//   S_HI     | pwm_out high, compare still high
//   S_HOLD   | pwm_out held high DT cycles after compare fell
//   S_DT_DN  | both low, counting DT before raising pwm_n
module pwm_seno_multi #(
  parameter int R       = 6,
  parameter int N       = 2000,
  parameter int CH      = 3,
  parameter int PH_STEP = 12,
  parameter int DT      = 2
) (
  input  logic            clk,
  input  logic            rst,
  pwm_seno_multi_if.slave bus
);
  localparam logic [R-1:0] CNT_MAX  = '1;
  localparam logic [15:0]  N_LAST   = 16'(N - 1);
  localparam logic [5:0]   IDX_LAST = 6'd35;

  if (R < 2 || N < 1 || N > 65535 || CH < 1 || CH > 8 ||
      PH_STEP < 0 || PH_STEP > 35 || DT < 0 || DT > (1 << R) / 4) begin : g_bad_cfg
    $error("pwm_seno_multi: parameter out of range");
  end

  // 16-bit sine samples: round(65536*(0.5+0.5*sin(2*pi*i/36))), clamped.
  function automatic logic [15:0] sine_f(input logic [5:0] i);
    case (i)
      6'd0:  return 16'd32768;  6'd1:  return 16'd38458;  6'd2:  return 16'd43975;
      6'd3:  return 16'd49152;  6'd4:  return 16'd53831;  6'd5:  return 16'd57870;
      6'd6:  return 16'd61146;  6'd7:  return 16'd63560;  6'd8:  return 16'd65038;
      6'd9:  return 16'd65535;  6'd10: return 16'd65038;  6'd11: return 16'd63560;
      6'd12: return 16'd61146;  6'd13: return 16'd57870;  6'd14: return 16'd53831;
      6'd15: return 16'd49152;  6'd16: return 16'd43975;  6'd17: return 16'd38458;
      6'd18: return 16'd32768;  6'd19: return 16'd27078;  6'd20: return 16'd21561;
      6'd21: return 16'd16384;  6'd22: return 16'd11705;  6'd23: return 16'd7666;
      6'd24: return 16'd4390;   6'd25: return 16'd1976;   6'd26: return 16'd498;
      6'd27: return 16'd0;      6'd28: return 16'd498;    6'd29: return 16'd1976;
      6'd30: return 16'd4390;   6'd31: return 16'd7666;   6'd32: return 16'd11705;
      6'd33: return 16'd16384;  6'd34: return 16'd21561;  6'd35: return 16'd27078;
      default: return 16'd32768;
    endcase
  endfunction

  // Rescale a sample to the carrier width with rounding, saturating at full scale.
  function automatic logic [R-1:0] sine_duty(input logic [5:0] i);
    logic [47:0] p;
    p = ((48'(sine_f(i)) << R) + 48'd32768) >> 16;
    if (p > 48'(CNT_MAX)) return CNT_MAX;
    return p[R-1:0];
  endfunction

  // Phase offset of channel k, reduced below 36 by repeated subtraction.
  function automatic logic [5:0] phase_off(input int k);
    int v;
    v = 0;
    for (int j = 0; j < k; j++) begin
      v = v + PH_STEP;
      if (v >= 36) v = v - 36;
    end
    return 6'(v);
  endfunction

  logic [R-1:0]  cnt;
  logic [15:0]   n;
  logic [5:0]    base;
  logic          tick;
  logic [CH-1:0] cmp;

  assign tick             = bus.en & (cnt == CNT_MAX);
  assign bus.period_tick  = tick;
  assign bus.step_idx     = base;

  // Carrier counter plus the slow table-step prescaler and base index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      n    <= '0;
      base <= '0;
    end else if (bus.en) begin
      cnt <= cnt + 1'b1;
      if (tick) begin
        if (n == N_LAST) begin
          n    <= '0;
          base <= (base == IDX_LAST) ? 6'd0 : base + 6'd1;
        end else begin
          n <= n + 16'd1;
        end
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    localparam logic [5:0] OFF  = phase_off(k);
    localparam logic [5:0] WRAP = 6'd36 - OFF;
    logic [5:0]   idx;
    logic [R-1:0] shadow;

    // Wrap-safe index: never leaves 6 bits because we subtract before adding past 35.
    always_comb begin
      idx = base + OFF;
      if (base >= WRAP) idx = base - WRAP;
    end

    // Shadow duty reloads only at carrier wrap, using the pre-advance base.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       shadow <= '0;
      else if (tick) shadow <= bus.mode ? bus.duty_in : sine_duty(idx);
    end

    assign cmp[k] = bus.en & (cnt < shadow);
  end

`ifdef PWM_COMPL_EN
  logic [CH-1:0] po;
  logic [CH-1:0] pn;
  assign bus.pwm_out = po;
  assign bus.pwm_n   = pn;

  for (genvar k = 0; k < CH; k++) begin : g_dt
    if (DT == 0) begin : g_nodt
      logic po_q, pn_q;
      // Without dead time the pair is simply the registered compare and its inverse.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          po_q <= 1'b0;
          pn_q <= 1'b0;
        end else begin
          po_q <= cmp[k];
          pn_q <= bus.en & ~cmp[k];
        end
      end
      assign po[k] = po_q;
      assign pn[k] = pn_q;
    end else begin : g_fsm
      localparam logic [2:0]   S_IDLE_N = 3'd0;
      localparam logic [2:0]   S_DT_UP  = 3'd1;
      localparam logic [2:0]   S_HI     = 3'd2;
      localparam logic [2:0]   S_HOLD   = 3'd3;
      localparam logic [2:0]   S_DT_DN  = 3'd4;
      localparam logic [R-1:0] DT_LOAD  = R'(DT - 1);
      logic [2:0]   st;
      logic [R-1:0] dt_cnt;
      logic         po_q, pn_q;

      // Break-before-make sequencer; a disabled generator restarts from a dead-time gap.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st     <= S_DT_DN;
          dt_cnt <= DT_LOAD;
          po_q   <= 1'b0;
          pn_q   <= 1'b0;
        end else if (!bus.en) begin
          st     <= S_DT_DN;
          dt_cnt <= DT_LOAD;
          po_q   <= 1'b0;
          pn_q   <= 1'b0;
        end else begin
          case (st)
            S_IDLE_N: if (cmp[k]) begin
              st     <= S_DT_UP;
              dt_cnt <= DT_LOAD;
              pn_q   <= 1'b0;
            end
            S_DT_UP: if (!cmp[k]) begin
              st     <= S_DT_DN;
              dt_cnt <= DT_LOAD;
            end else if (dt_cnt == '0) begin
              st   <= S_HI;
              po_q <= 1'b1;
            end else begin
              dt_cnt <= dt_cnt - 1'b1;
            end
            S_HI: if (!cmp[k]) begin
              st     <= S_HOLD;
              dt_cnt <= DT_LOAD;
            end
            S_HOLD: if (dt_cnt == '0) begin
              st     <= S_DT_DN;
              dt_cnt <= DT_LOAD;
              po_q   <= 1'b0;
            end else begin
              dt_cnt <= dt_cnt - 1'b1;
            end
            S_DT_DN: if (cmp[k]) begin
              st     <= S_DT_UP;
              dt_cnt <= DT_LOAD;
            end else if (dt_cnt == '0) begin
              st   <= S_IDLE_N;
              pn_q <= 1'b1;
            end else begin
              dt_cnt <= dt_cnt - 1'b1;
            end
            default: begin
              st     <= S_DT_DN;
              dt_cnt <= DT_LOAD;
              po_q   <= 1'b0;
              pn_q   <= 1'b0;
            end
          endcase
        end
      end
      assign po[k] = po_q;
      assign pn[k] = pn_q;
    end
  end
`else
  logic [CH-1:0] pwm_r;

  // Registered compare keeps the outputs glitch-free, one cycle behind cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_r <= '0;
    else     pwm_r <= cmp;
  end
  assign bus.pwm_out = pwm_r;
`endif
endmodule

// File: tb/tb_pwm_seno_multi.sv
`timescale 1ns/1ps
module tb_pwm_seno_multi;
  localparam int R  = 6;
  localparam int CH = 3;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   vectors = 0;
  int   miscompares = 0;

  // Hand-computed duty table for R=6.
  int dtab [36] = '{32, 38, 43, 48, 53, 57, 60, 62, 63, 63, 63, 62,
                    60, 57, 53, 48, 43, 38, 32, 26, 21, 16, 11,  7,
                     4,  2,  0,  0,  0,  2,  4,  7, 11, 16, 21, 26};

  always #5 clk = ~clk;

  pwm_seno_multi_if #(.R(R), .CH(CH)) bus1 ();
  pwm_seno_multi_if #(.R(R), .CH(CH)) bus3 ();

  pwm_seno_multi #(.R(R), .N(1), .CH(CH), .PH_STEP(12), .DT(2)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1));
  pwm_seno_multi #(.R(R), .N(3), .CH(CH), .PH_STEP(12), .DT(2)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one carrier period of dut1 starting at cnt=0; optionally changes duty_in mid-period.
  task automatic run_period1(input int chg_at, input logic [5:0] chg_val,
                             output int h0, output int h1, output int h2,
                             output int tick_err, output int sidx);
    h0 = 0; h1 = 0; h2 = 0; tick_err = 0;
    sidx = int'(bus1.step_idx);
    for (int j = 0; j < 64; j++) begin
      if (j == chg_at) bus1.duty_in = chg_val;
      h0 += int'(bus1.pwm_out[0]);
      h1 += int'(bus1.pwm_out[1]);
      h2 += int'(bus1.pwm_out[2]);
      if (bus1.period_tick !== (j == 63)) tick_err++;
      tick;
    end
  endtask

  task automatic test_reset;
    bus1.en = 1'b1; bus1.mode = 1'b0; bus1.duty_in = '0;
    rst1 = 1'b1;
    repeat (2) tick;
    rst1 = 1'b0;
    repeat (100) tick;
    vectors++;
    if (bus1.pwm_out !== 3'b010) begin
      miscompares++;
      $display("FAIL pre_reset_pwm: got %b expected 010", bus1.pwm_out);
    end
    rst1 = 1'b1;
    #1;
    vectors++;
    if (bus1.pwm_out !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_pwm: got %b expected 000", bus1.pwm_out);
    end
    vectors++;
    if (bus1.step_idx !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_step_idx: got %0d expected 0", bus1.step_idx);
    end
    vectors++;
    if (bus1.period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_period_tick: got %b expected 0", bus1.period_tick);
    end
    tick;
    rst1 = 1'b0;
  endtask

  task automatic test_first_period;
    int h0, h1, h2, te, si;
    run_period1(-1, 6'd0, h0, h1, h2, te, si);
    vectors++;
    if (h0 + h1 + h2 !== 0) begin
      miscompares++;
      $display("FAIL first_period_high: got %0d expected 0", h0 + h1 + h2);
    end
    vectors++;
    if (te !== 0) begin
      miscompares++;
      $display("FAIL first_period_tick: got %0d misplaced ticks expected 0", te);
    end
  endtask

  task automatic test_phase_duties;
    int h0, h1, h2, te, si;
    run_period1(-1, 6'd0, h0, h1, h2, te, si);
    vectors++;
    if (h0 !== 32) begin miscompares++; $display("FAIL phase_ch0: got %0d expected 32", h0); end
    vectors++;
    if (h1 !== 60) begin miscompares++; $display("FAIL phase_ch1: got %0d expected 60", h1); end
    vectors++;
    if (h2 !== 4) begin miscompares++; $display("FAIL phase_ch2: got %0d expected 4", h2); end
    vectors++;
    if (si !== 1) begin miscompares++; $display("FAIL phase_step_idx: got %0d expected 1", si); end
    vectors++;
    if (te !== 0) begin miscompares++; $display("FAIL phase_tick: got %0d expected 0", te); end
  endtask

  task automatic test_index_wrap;
    int h0, h1, h2, te, si;
    for (int p = 2; p <= 40; p++) begin
      run_period1(-1, 6'd0, h0, h1, h2, te, si);
      vectors++;
      if (si !== p % 36) begin
        miscompares++;
        $display("FAIL wrap_step_idx p%0d: got %0d expected %0d", p, si, p % 36);
      end
`ifndef PWM_COMPL_EN
      vectors++;
      if (h0 !== dtab[(p - 1) % 36]) begin
        miscompares++;
        $display("FAIL wrap_ch0 p%0d: got %0d expected %0d", p, h0, dtab[(p - 1) % 36]);
      end
      vectors++;
      if (h1 !== dtab[(p - 1 + 12) % 36]) begin
        miscompares++;
        $display("FAIL wrap_ch1 p%0d: got %0d expected %0d", p, h1, dtab[(p - 1 + 12) % 36]);
      end
      vectors++;
      if (h2 !== dtab[(p - 1 + 24) % 36]) begin
        miscompares++;
        $display("FAIL wrap_ch2 p%0d: got %0d expected %0d", p, h2, dtab[(p - 1 + 24) % 36]);
      end
`endif
    end
  endtask

  task automatic test_bypass;
    int h0, h1, h2, te, si;
    bus1.mode = 1'b1;
    bus1.duty_in = 6'd10;
    run_period1(-1, 6'd0, h0, h1, h2, te, si);
    vectors++;
    if (h0 !== 53 || h1 !== 43 || h2 !== 0) begin
      miscompares++;
      $display("FAIL bypass_unaffected: got %0d/%0d/%0d expected 53/43/0", h0, h1, h2);
    end
    run_period1(30, 6'd20, h0, h1, h2, te, si);
    vectors++;
    if (h0 !== 10 || h1 !== 10 || h2 !== 10) begin
      miscompares++;
      $display("FAIL bypass_10: got %0d/%0d/%0d expected 10/10/10", h0, h1, h2);
    end
    run_period1(-1, 6'd0, h0, h1, h2, te, si);
    vectors++;
    if (h0 !== 20 || h1 !== 20 || h2 !== 20) begin
      miscompares++;
      $display("FAIL bypass_20: got %0d/%0d/%0d expected 20/20/20", h0, h1, h2);
    end
  endtask

`ifdef PWM_COMPL_EN
  task automatic test_compl;
    int h0, h1, h2, te, si;
    int hp [3];
    int hn [3];
    int first_hi, overlap;
    bus1.duty_in = 6'd32;
    run_period1(-1, 6'd0, h0, h1, h2, te, si);
    run_period1(-1, 6'd0, h0, h1, h2, te, si);
    hp = '{0, 0, 0}; hn = '{0, 0, 0};
    first_hi = -1; overlap = 0;
    for (int j = 0; j < 64; j++) begin
      for (int c = 0; c < 3; c++) begin
        hp[c] += int'(bus1.pwm_out[c]);
        hn[c] += int'(bus1.pwm_n[c]);
        if (bus1.pwm_out[c] && bus1.pwm_n[c]) overlap++;
      end
      if (first_hi < 0 && bus1.pwm_out[0]) first_hi = j;
      tick;
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (hp[c] !== 32) begin miscompares++; $display("FAIL compl_out ch%0d: got %0d expected 32", c, hp[c]); end
      vectors++;
      if (hn[c] !== 28) begin miscompares++; $display("FAIL compl_n ch%0d: got %0d expected 28", c, hn[c]); end
    end
    vectors++;
    if (first_hi !== 3) begin miscompares++; $display("FAIL compl_first_hi: got %0d expected 3", first_hi); end
    vectors++;
    if (overlap !== 0) begin miscompares++; $display("FAIL compl_overlap: got %0d expected 0", overlap); end
  endtask
`endif

  task automatic test_step_n3;
    int n_t, since, frz_err;
    logic [5:0] prev;
    bus3.en = 1'b1; bus3.mode = 1'b0; bus3.duty_in = '0;
    tick;
    rst3 = 1'b0;
    for (int s = 1; s <= 2; s++) begin
      prev = bus3.step_idx;
      n_t = 0;
      while (bus3.step_idx == prev && n_t < 1000) begin tick; n_t++; end
      vectors++;
      if (n_t !== 192) begin miscompares++; $display("FAIL n3_step_time %0d: got %0d expected 192", s, n_t); end
      vectors++;
      if (bus3.step_idx !== 6'(s)) begin
        miscompares++;
        $display("FAIL n3_step_val %0d: got %0d expected %0d", s, bus3.step_idx, s);
      end
    end
    repeat (100) tick;
    since = 100;
`ifndef PWM_COMPL_EN
    vectors++;
    if (bus3.pwm_out !== 3'b011) begin miscompares++; $display("FAIL n3_pre_freeze: got %b expected 011", bus3.pwm_out); end
`endif
    bus3.en = 1'b0;
    frz_err = 0;
    for (int j = 0; j < 50; j++) begin
      tick;
      if (bus3.pwm_out !== 3'b000 || bus3.period_tick !== 1'b0 || bus3.step_idx !== 6'd2) frz_err++;
    end
    since += 50;
    vectors++;
    if (frz_err !== 0) begin miscompares++; $display("FAIL n3_freeze: got %0d bad cycles expected 0", frz_err); end
    bus3.en = 1'b1;
    tick;
    since += 1;
`ifndef PWM_COMPL_EN
    vectors++;
    if (bus3.pwm_out !== 3'b011) begin miscompares++; $display("FAIL n3_resume: got %b expected 011", bus3.pwm_out); end
`endif
    n_t = 0;
    while (bus3.step_idx == 6'd2 && n_t < 1000) begin tick; n_t++; end
    since += n_t;
    vectors++;
    if (since !== 242) begin miscompares++; $display("FAIL n3_shifted_step: got %0d expected 242", since); end
    vectors++;
    if (bus3.step_idx !== 6'd3) begin miscompares++; $display("FAIL n3_step_val 3: got %0d expected 3", bus3.step_idx); end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.en = 1'b0; bus1.mode = 1'b0; bus1.duty_in = '0;
    bus3.en = 1'b0; bus3.mode = 1'b0; bus3.duty_in = '0;
    #2;
    test_reset;
    test_first_period;
    test_phase_duties;
    test_index_wrap;
    test_bypass;
`ifdef PWM_COMPL_EN
    test_compl;
`endif
    test_step_n3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pwm_seno_multi.md
Name: pwm_seno_multi

Overview:
Multi-channel sine-modulated PWM generator: one shared R-bit carrier counter drives CH comparators.
Each channel reads a fixed 36-step sine duty table, offset from its neighbour by PH_STEP table steps (e.g. 3-phase).
The table index advances once every N carrier periods.
Duties are shadow-registered at carrier wrap, so outputs are glitch-free.
A bypass mode drives all channels from an external duty word.

Parameters:
R, 6, carrier counter width; carrier period = 2^R clk cycles
N, 2000, carrier periods per table step (1..65535)
CH, 3, number of PWM channels (1..8)
PH_STEP, 12, phase offset between channel k and k+1 in table steps (0..35)
DT, 2, dead-time in clk cycles (used only with PWM_COMPL_EN, 0..2^R/4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  1 = run; 0 = freeze counters, force outputs low
mode  input  1  0 = sine table, 1 = bypass (duty_in on all channels)
duty_in  input  R  bypass duty, sampled only at carrier wrap
pwm_out  output  CH  PWM outputs, bit k = channel k
step_idx  output  6  current base table index (channel 0), 0..35
period_tick  output  1  high during the last cycle of each carrier period
pwm_n  output  CH  complementary outputs (present only with PWM_COMPL_EN)

Behaviour:
- Reset (async, rst=1):
  - cnt=0, n=0, base=0.
  - All shadow duties = 0.
  - pwm_out=0, period_tick=0, step_idx=0.
  - Reset mid-period aborts immediately; no partial state survives.
- Carrier:
  - cnt increments by 1 each clk while en=1 and wraps 2^R-1 -> 0.
  - period_tick = en & (cnt==2^R-1), decoded combinationally.
- Step counter (on each edge where period_tick=1):
  - If n==N-1: n<=0, and base<=(base==35)?0:base+1.
  - Else: n<=n+1.
- Channel index: idx_k = (base + k*PH_STEP) mod 36, computed with a 6-bit wrap-safe add. No modulo operator on variable widths.
- Table:
  - F[i] = round(65536*(0.5+0.5*sin(2*pi*i/36))), clamped to 65535; stored as constants.
  - Duty D[i] = (F[i]*2^R + 2^15) >> 16, saturated to 2^R-1.
- Shadow load: on each period_tick edge, every channel's shadow duty loads:
  - mode=0: D[idx_k] using base before this edge's advance (one-period lag).
  - mode=1: duty_in.
- mode and duty_in changes mid-period take effect only at the next wrap.
- Output: pwm_out[k] = en & (cnt < shadow_k), registered so outputs are glitch-free; one clk latency versus cnt.
  - Duty 0 -> constant low.
  - Max duty 2^R-1 -> low one cycle per period.
- en=0:
  - cnt, n, base and shadows hold; pwm_out=0.
  - Resuming continues from the held cnt.
- First carrier period after reset: all outputs low, because shadows are 0.

Optional Feature:
Macro PWM_COMPL_EN.
- Defined: adds port pwm_n.
  - pwm_n[k] is the complement of pwm_out[k], with DT cycles of both-low inserted after every edge of either output.
  - Implemented with a per-channel DT-cycle down-counter.
  - If a pulse or gap is shorter than DT, the corresponding output stays low for that interval.
  - Reset and en=0: pwm_n=0.
- Not defined: port pwm_n and dead-time logic are absent; all other behaviour is identical.

Test Plan:
1. Reset and first period, R=6, N=1, CH=3, mode=0, en=1: assert rst mid-run -> all outputs 0 at once; after release, pwm_out=0 for the first 64 cycles, period_tick high at cycle 63.
2. Phase duties, same setup: in the second period, channel high-times are ch0=32, ch1=60 (idx 12), ch2=4 (idx 24); step_idx=1.
3. Index wrap and saturation, N=1: run 40 periods -> step_idx sequence 35 -> 0; period loading idx 9 on ch0 has 63 high cycles; idx 27 gives 0 high cycles.
4. N=3 stepping: step_idx increments exactly every 192 clk; en low for 50 cycles mid-period -> outputs 0, step timing shifts by exactly 50 cycles.
5. Bypass: mode=1, duty_in=10, changed to 20 mid-period -> current period unaffected; next period all channels high 10 cycles, then 20 in the following period.
6. PWM_COMPL_EN, DT=2, bypass duty 32: pwm_out high 32 (starting 2 cycles late), pwm_n high 28, never both high.
